// File: rtl/volume_pkg.sv
// Shared constants, gain lookup and multiplier FSM encoding for the volume scaler.
package volume_pkg;

  localparam int unsigned MAX_VOL_LEVEL = 10;
  // Gain is Q8: 256 represents unity, so 9 bits are needed.
  localparam int unsigned Q8_W    = 9;
  localparam int unsigned Q8_FRAC = 8;

  typedef enum logic [1:0] {
    StIdle,
    StMult,
    StDone
  } mult_state_e;

  // round(level * 256 / 10); levels above 10 clamp to unity.
  function automatic logic [Q8_W-1:0] gain_q8(input logic [3:0] level);
    logic [Q8_W-1:0] q8;
    case (level)
      4'd0:    q8 = 9'd0;
      4'd1:    q8 = 9'd26;
      4'd2:    q8 = 9'd51;
      4'd3:    q8 = 9'd77;
      4'd4:    q8 = 9'd102;
      4'd5:    q8 = 9'd128;
      4'd6:    q8 = 9'd154;
      4'd7:    q8 = 9'd179;
      4'd8:    q8 = 9'd205;
      4'd9:    q8 = 9'd230;
      default: q8 = 9'd256;
    endcase
    return q8;
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// Sequential SAMPLE_W x 9-bit shift-add multiplier, one multiplier bit per clock, LSB first.
module shift_add_mult
  import volume_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [SAMPLE_W-1:0]      sample,
  input  logic [Q8_W-1:0]          gain,
  output logic                     busy,
  output logic                     done,
  output logic [SAMPLE_W+Q8_W-1:0] product
);

  localparam int unsigned ACC_W = SAMPLE_W + Q8_W;
  localparam int unsigned IDX_W = $clog2(Q8_W);

  logic [SAMPLE_W-1:0] a_q;
  logic [Q8_W-1:0]     b_q;
  logic [ACC_W-1:0]    acc_q, acc_d, partial;
  logic [IDX_W-1:0]    idx_q;
  logic                busy_q;
  logic                last;

  always_comb begin
    partial = b_q[idx_q] ? (ACC_W'(a_q) << idx_q) : '0;
    acc_d   = acc_q + partial;
    last    = (idx_q == IDX_W'(Q8_W - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      a_q    <= sample;
      b_q    <= gain;
      acc_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_d;
      idx_q <= idx_q + IDX_W'(1);
      if (last) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  // done marks the cycle whose closing edge folds in the final bit; product is that final sum.
  assign done    = busy_q && last;
  assign product = acc_d;

endmodule

// File: rtl/volume_scaler.sv
// Captures BCD volume, ramps the gain toward it one level at a time and scales
// incoming samples by the current gain through a sequential multiplier.
module volume_scaler
  import volume_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned RAMP_DIV = 1000,
  parameter int unsigned MAX_VOL  = MAX_VOL_LEVEL
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          volume1,
  input  logic [3:0]          volume0,
  input  logic                mudou_volume,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                out_valid,
  output logic [3:0]          ganho_atual,
  output logic                erro_bcd
);

  localparam int unsigned ACC_W   = SAMPLE_W + Q8_W;
  localparam int unsigned CNT_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAMP_DIV - 1);

  // Volume capture and gain ramp
  logic [7:0]       req_level;
  logic             vol_legal;
  logic [3:0]       target_q, target_d;
  logic [3:0]       gain_q, gain_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             erro_q, erro_d;

  assign req_level = 8'(volume1) * 8'd10 + 8'(volume0);
  assign vol_legal = (volume1 <= 4'd1) && (volume0 <= 4'd9) && (req_level <= 8'(MAX_VOL));

  always_comb begin
    target_d = target_q;
    gain_d   = gain_q;
    cnt_d    = cnt_q;
    erro_d   = erro_q;
    if (gain_q == target_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      gain_d = (gain_q < target_q) ? gain_q + 4'd1 : gain_q - 4'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A capture clears the counter even when a step happens on the same edge.
    if (mudou_volume) begin
      if (vol_legal) begin
        target_d = req_level[3:0];
        erro_d   = 1'b0;
        cnt_d    = '0;
      end else begin
        erro_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q <= '0;
      gain_q   <= '0;
      cnt_q    <= '0;
      erro_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      gain_q   <= gain_d;
      cnt_q    <= cnt_d;
      erro_q   <= erro_d;
    end
  end

  assign ganho_atual = gain_q;
  assign erro_bcd    = erro_q;

  // Sample handshake and multiply sequencing
  mult_state_e         state_q;
  logic [SAMPLE_W-1:0] sample_out_q;
  logic                out_valid_q;
  logic                accept;
  logic                mult_busy, mult_done;
  logic [ACC_W-1:0]    product;
  logic [SAMPLE_W:0]   scaled;
  logic [SAMPLE_W-1:0] saturated;
  logic                unused_lsb;

  assign sample_ready = (state_q == StIdle) && !mult_busy;
  assign accept       = sample_valid && sample_ready;

  shift_add_mult #(
    .SAMPLE_W(SAMPLE_W)
  ) u_mult (
    .clk    (clk),
    .reset  (reset),
    .start  (accept),
    .sample (sample_in),
    .gain   (gain_q8(gain_q)),
    .busy   (mult_busy),
    .done   (mult_done),
    .product(product)
  );

  assign scaled     = product[ACC_W-1:Q8_FRAC];
  assign saturated  = scaled[SAMPLE_W] ? '1 : scaled[SAMPLE_W-1:0];
  assign unused_lsb = ^product[Q8_FRAC-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sample_out_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          out_valid_q <= 1'b0;
          if (accept) state_q <= StMult;
        end
        StMult: begin
          if (mult_done) begin
            sample_out_q <= saturated;
            out_valid_q  <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign sample_out = sample_out_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_volume_scaler.sv
// Directed and randomized checks of volume_scaler against an arithmetic reference model.
module tb_volume_scaler;

  localparam int unsigned SW   = 8;
  localparam int unsigned RDIV = 4;

  logic          clk;
  logic          reset;
  logic [3:0]    volume1, volume0;
  logic          mudou_volume;
  logic [SW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic [SW-1:0] sample_out;
  logic          out_valid;
  logic [3:0]    ganho_atual;
  logic          erro_bcd;

  int n_checks = 0;
  int n_fail   = 0;

  volume_scaler #(
    .SAMPLE_W(SW),
    .RAMP_DIV(RDIV),
    .MAX_VOL (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .volume1     (volume1),
    .volume0     (volume0),
    .mudou_volume(mudou_volume),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_out  (sample_out),
    .out_valid   (out_valid),
    .ganho_atual (ganho_atual),
    .erro_bcd    (erro_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // Reference model: Q8 gain = round(g*256/10); output = floor(s*q8/256) saturated.
  function automatic int ref_q8(input int g);
    return (g * 256 + 5) / 10;
  endfunction

  function automatic int ref_scale(input int s, input int g);
    int r;
    r = (s * ref_q8(g)) / 256;
    return (r > 255) ? 255 : r;
  endfunction

  // Gain m cycles after a capture: one step per RDIV cycles, never past the target.
  function automatic int ref_ramp(input int g0, input int t, input int m);
    int steps;
    steps = m / RDIV;
    if (t >= g0) return (g0 + steps > t) ? t : g0 + steps;
    return (g0 - steps < t) ? t : g0 - steps;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [3:0] tens, input logic [3:0] units);
    volume1      = tens;
    volume0      = units;
    mudou_volume = 1'b1;
    @(negedge clk);
    mudou_volume = 1'b0;
  endtask

  task automatic wait_gain(input int g);
    for (int i = 0; i < 200 && ganho_atual != 4'(g); i++) @(negedge clk);
    chk("gain_settle", 32'(ganho_atual), 32'(g));
  endtask

  // One sample through the pipe; optionally request a new volume mid-multiply.
  task automatic run_sample(input int s, input int g, input bit bump);
    chk("ready_idle", 32'(sample_ready), 32'd1);
    sample_in    = SW'(s);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (bump && j == 1) begin
        volume1 = 4'd1; volume0 = 4'd0; mudou_volume = 1'b1;
      end else begin
        mudou_volume = 1'b0;
      end
      chk("ov_early", 32'(out_valid), 32'd0);
      if (j == 4) chk("ready_busy", 32'(sample_ready), 32'd0);
      @(negedge clk);
    end
    mudou_volume = 1'b0;
    chk("ov_pulse", 32'(out_valid), 32'd1);
    chk("result", 32'(sample_out), 32'(ref_scale(s, g)));
    @(negedge clk);
    chk("ov_drop", 32'(out_valid), 32'd0);
    chk("result_hold", 32'(sample_out), 32'(ref_scale(s, g)));
  endtask

  initial begin
    int last_acc, n_acc, n_out, s;
    reset = 1'b0; volume1 = '0; volume0 = '0; mudou_volume = 1'b0;
    sample_in = '0; sample_valid = 1'b0;
    #1;
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_gain", 32'(ganho_atual), 32'd0);
    chk("rst_err", 32'(erro_bcd), 32'd0);
    chk("rst_out", 32'(sample_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Ramp 0 -> 10, one step every RDIV cycles
    capture(4'd1, 4'd0);
    for (int m = 0; m <= 44; m++) begin
      chk("ramp_up", 32'(ganho_atual), 32'(ref_ramp(0, 10, m)));
      @(negedge clk);
    end
    chk("err_legal", 32'(erro_bcd), 32'd0);

    // Gain 10
    run_sample(200, 10, 1'b0);
    for (int i = 0; i < 3; i++) run_sample(int'($urandom_range(0, 255)), 10, 1'b0);

    // Held valid: accept every 11 cycles, every output 50
    sample_in = SW'(50); sample_valid = 1'b1;
    last_acc = -1; n_acc = 0; n_out = 0;
    for (int c = 0; c < 50; c++) begin
      if (sample_ready) begin
        if (last_acc >= 0) chk("accept_gap", 32'(c - last_acc), 32'd11);
        last_acc = c;
        n_acc++;
      end
      if (out_valid) begin
        chk("held_out", 32'(sample_out), 32'd50);
        n_out++;
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    chk("held_accepts", 32'(n_acc), 32'd5);
    chk("held_outputs", 32'(n_out), 32'd4);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    chk("held_drain_ov", 32'(out_valid), 32'd1);
    chk("held_drain", 32'(sample_out), 32'd50);
    @(negedge clk);

    // Illegal captures keep the target, flag sticky error
    capture(4'd1, 4'd5);
    chk("err_set", 32'(erro_bcd), 32'd1);
    capture(4'd0, 4'd10);
    repeat (8) @(negedge clk);
    chk("err_sticky", 32'(erro_bcd), 32'd1);
    chk("gain_kept", 32'(ganho_atual), 32'd10);

    // Legal capture clears error, descend 10 -> 7
    capture(4'd0, 4'd7);
    chk("err_clear", 32'(erro_bcd), 32'd0);
    for (int m = 0; m <= 16; m++) begin
      chk("ramp_down", 32'(ganho_atual), 32'(ref_ramp(10, 7, m)));
      @(negedge clk);
    end

    // Gain 5
    capture(4'd0, 4'd5);
    wait_gain(5);
    run_sample(200, 5, 1'b0);
    for (int i = 0; i < 3; i++) run_sample(int'($urandom_range(0, 255)), 5, 1'b0);

    // Gain 3, then a volume change during the multiply
    capture(4'd0, 4'd3);
    wait_gain(3);
    run_sample(255, 3, 1'b0);
    s = int'($urandom_range(0, 255));
    run_sample(s, 3, 1'b0);
    run_sample(255, 3, 1'b1);
    chk("bump_err", 32'(erro_bcd), 32'd0);
    wait_gain(10);

    // Random gains and samples
    for (int i = 0; i < 4; i++) begin
      int g;
      g = int'($urandom_range(0, 10));
      capture(4'(g / 10), 4'(g % 10));
      wait_gain(g);
      run_sample(int'($urandom_range(0, 255)), g, 1'b0);
    end

    // Reset mid-multiply aborts without an output pulse
    capture(4'd1, 4'd0);
    wait_gain(10);
    sample_in = SW'(123); sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_gain", 32'(ganho_atual), 32'd0);
    chk("mid_rst_ready", 32'(sample_ready), 32'd1);
    chk("mid_rst_out", 32'(sample_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    n_out = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid) n_out++;
      @(negedge clk);
    end
    chk("mid_rst_no_pulse", 32'(n_out), 32'd0);
    chk("mid_rst_gain_hold", 32'(ganho_atual), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
